// File: rtl/pe_mac_cfg_if.sv
// Operand, partial-sum and control bundle of one pe_mac_cfg cell.
// The array (master) drives the inputs; the PE (slave) drives the registered outputs.
interface pe_mac_cfg_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 16
);
  logic                  mode;
  logic                  signed_en;
  logic                  clear;
  logic                  drain;
  logic [DATA_WIDTH-1:0] a_in;
  logic                  a_vld_in;
  logic [DATA_WIDTH-1:0] b_in;
  logic                  b_vld_in;
  logic [ACC_WIDTH-1:0]  c_in;
  logic                  c_vld_in;
  logic [DATA_WIDTH-1:0] a_out;
  logic                  a_vld_out;
  logic [DATA_WIDTH-1:0] b_out;
  logic                  b_vld_out;
  logic [ACC_WIDTH-1:0]  c_out;
  logic                  c_vld_out;
  logic                  ovf;

  modport master (
    output mode, signed_en, clear, drain,
    output a_in, a_vld_in, b_in, b_vld_in, c_in, c_vld_in,
    input  a_out, a_vld_out, b_out, b_vld_out, c_out, c_vld_out, ovf
  );

  modport slave (
    input  mode, signed_en, clear, drain,
    input  a_in, a_vld_in, b_in, b_vld_in, c_in, c_vld_in,
    output a_out, a_vld_out, b_out, b_vld_out, c_out, c_vld_out, ovf
  );
endinterface

// File: rtl/pe_mac_cfg.sv
// Configurable systolic MAC cell: PASS mode adds into the partial sum from above,
// OS mode accumulates locally and drains its result (then ROW upstream results) downward.
module pe_mac_cfg #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 16,
  parameter int SATURATE   = 1,
  parameter int ROW        = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  pe_mac_cfg_if.slave bus
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam int CW = (ROW > 0) ? $clog2(ROW + 1) : 1;

  typedef enum logic [1:0] {
    ACC,
    SELF,
    CHAIN
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] a_q, b_q;
  logic                  a_vld_q, b_vld_q;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [ACC_WIDTH-1:0]  c_q, c_d;
  logic                  c_vld_q, c_vld_d;
  logic                  ovf_q, ovf_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic                  fire;
  logic [PW-1:0]         a_ext, b_ext, prod;
  logic [ACC_WIDTH:0]    acc_sum, c_sum, prod_sum;
  logic [ACC_WIDTH-1:0]  acc_next;
  logic                  ovf_next;

  // Returns {overflow, result}; both operands are extended to ACC_WIDTH+1 bits first.
  function automatic logic [ACC_WIDTH:0] add_sat(input logic [ACC_WIDTH-1:0] x,
                                                 input logic [PW-1:0] p,
                                                 input logic sgn);
    logic [ACC_WIDTH:0]   xe;
    logic [ACC_WIDTH:0]   pe;
    logic [ACC_WIDTH:0]   s;
    logic [ACC_WIDTH-1:0] res;
    logic                 of;
    xe  = {sgn & x[ACC_WIDTH-1], x};
    pe  = sgn ? {{(ACC_WIDTH + 1 - PW){p[PW-1]}}, p} : {{(ACC_WIDTH + 1 - PW){1'b0}}, p};
    s   = xe + pe;
    of  = sgn ? (s[ACC_WIDTH] != s[ACC_WIDTH-1]) : s[ACC_WIDTH];
    res = s[ACC_WIDTH-1:0];
    if (of && (SATURATE != 0)) begin
      if (!sgn)             res = '1;
      else if (s[ACC_WIDTH]) res = {1'b1, {(ACC_WIDTH - 1){1'b0}}};
      else                  res = {1'b0, {(ACC_WIDTH - 1){1'b1}}};
    end
    return {of, res};
  endfunction

  always_comb begin
    fire  = bus.a_vld_in & bus.b_vld_in;
    a_ext = bus.signed_en ? {{DATA_WIDTH{bus.a_in[DATA_WIDTH-1]}}, bus.a_in}
                          : {{DATA_WIDTH{1'b0}}, bus.a_in};
    b_ext = bus.signed_en ? {{DATA_WIDTH{bus.b_in[DATA_WIDTH-1]}}, bus.b_in}
                          : {{DATA_WIDTH{1'b0}}, bus.b_in};
    prod  = fire ? (a_ext * b_ext) : '0;
    acc_sum  = add_sat(acc_q, prod, bus.signed_en);
    c_sum    = add_sat(bus.c_in, prod, bus.signed_en);
    // Adding to zero just extends the product to accumulator width.
    prod_sum = add_sat('0, prod, bus.signed_en);
    acc_next = bus.clear ? prod_sum[ACC_WIDTH-1:0] : acc_sum[ACC_WIDTH-1:0];
    ovf_next = bus.clear ? 1'b0 : (ovf_q | acc_sum[ACC_WIDTH]);
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    c_d     = c_q;
    c_vld_d = 1'b0;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    case (state_q)
      ACC: begin
        if (!bus.mode) begin
          c_vld_d = bus.c_vld_in;
          if (bus.c_vld_in) begin
            c_d   = c_sum[ACC_WIDTH-1:0];
            ovf_d = ovf_q | c_sum[ACC_WIDTH];
          end
          if (bus.clear) acc_d = prod_sum[ACC_WIDTH-1:0];
        end else if (bus.drain) begin
          c_d     = acc_sum[ACC_WIDTH-1:0];
          c_vld_d = 1'b1;
          acc_d   = '0;
          ovf_d   = ovf_q | acc_sum[ACC_WIDTH];
          state_d = SELF;
        end else begin
          acc_d = acc_next;
          ovf_d = ovf_next;
        end
      end
      SELF: begin
        acc_d = acc_next;
        ovf_d = ovf_next;
        if (ROW == 0) begin
          state_d = ACC;
        end else begin
          state_d = CHAIN;
          cnt_d   = CW'(ROW);
        end
      end
      CHAIN: begin
        acc_d   = acc_next;
        ovf_d   = ovf_next;
        c_vld_d = bus.c_vld_in;
        if (bus.c_vld_in) begin
          c_d   = bus.c_in;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = ACC;
        end
      end
      default: state_d = ACC;
    endcase
    if (bus.clear) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACC;
      acc_q   <= '0;
      c_q     <= '0;
      c_vld_q <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      c_q     <= c_d;
      c_vld_q <= c_vld_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  // Operand registers only load on a valid beat so data stays stable between beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      a_vld_q <= 1'b0;
      b_vld_q <= 1'b0;
    end else begin
      a_vld_q <= bus.a_vld_in;
      b_vld_q <= bus.b_vld_in;
      if (bus.a_vld_in) a_q <= bus.a_in;
      if (bus.b_vld_in) b_q <= bus.b_in;
    end
  end

  assign bus.a_out     = a_q;
  assign bus.a_vld_out = a_vld_q;
  assign bus.b_out     = b_q;
  assign bus.b_vld_out = b_vld_q;
  assign bus.c_out     = c_q;
  assign bus.c_vld_out = c_vld_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_pe_mac_cfg.sv
// Scoreboard bench for pe_mac_cfg: a saturating ROW=2 cell and a wrapping ROW=0 cell
// receive identical stimulus; expected c_out words are queued per cell and popped on c_vld_out.
module tb_pe_mac_cfg;
  localparam int DW = 8;
  localparam int AW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errCount = 0;
  int   checkCount = 0;
  logic [AW-1:0] expQ0[$];
  logic [AW-1:0] expQ1[$];

  pe_mac_cfg_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW)) bus0 ();
  pe_mac_cfg_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW)) bus1 ();

  pe_mac_cfg #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .SATURATE(1), .ROW(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );
  pe_mac_cfg #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .SATURATE(0), .ROW(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [DW-1:0] a, input logic av,
                               input logic [DW-1:0] b, input logic bv,
                               input logic [AW-1:0] c, input logic cv,
                               input logic md, input logic sgn,
                               input logic clr, input logic drn);
    bus0.a_in = a;  bus0.a_vld_in = av; bus0.b_in = b; bus0.b_vld_in = bv;
    bus0.c_in = c;  bus0.c_vld_in = cv; bus0.mode = md; bus0.signed_en = sgn;
    bus0.clear = clr; bus0.drain = drn;
    bus1.a_in = a;  bus1.a_vld_in = av; bus1.b_in = b; bus1.b_vld_in = bv;
    bus1.c_in = c;  bus1.c_vld_in = cv; bus1.mode = md; bus1.signed_en = sgn;
    bus1.clear = clr; bus1.drain = drn;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic md);
    applyStimulus(0, 0, 0, 0, 0, 0, md, 0, 0, 0);
  endtask

  task automatic passOp(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [AW-1:0] c,
                        input logic sgn, input logic [AW-1:0] e0, input logic [AW-1:0] e1);
    expQ0.push_back(e0);
    expQ1.push_back(e1);
    applyStimulus(a, 1, b, 1, c, 1, 0, sgn, 0, 0);
  endtask

  always @(negedge clk) begin : monitor
    logic [AW-1:0] e;
    if (rst_n) begin
      if (bus0.c_vld_out) begin
        if (expQ0.size() == 0) checkOutput("c0_unexpected_vld", bus0.c_vld_out, 0);
        else begin
          e = expQ0.pop_front();
          checkOutput("c0_out", bus0.c_out, e);
        end
      end
      if (bus1.c_vld_out) begin
        if (expQ1.size() == 0) checkOutput("c1_unexpected_vld", bus1.c_vld_out, 0);
        else begin
          e = expQ1.pop_front();
          checkOutput("c1_out", bus1.c_out, e);
        end
      end
    end
  end

  initial begin : stim
    logic [DW-1:0] ra, rb;
    logic [AW-1:0] rc, ex;
    int pv;

    idle(0);
    idle(0);
    checkOutput("rst_c_out", bus0.c_out, 0);
    checkOutput("rst_c_vld", bus0.c_vld_out, 0);
    checkOutput("rst_a_out", bus0.a_out, 0);
    checkOutput("rst_b_vld", bus0.b_vld_out, 0);
    checkOutput("rst_ovf", bus0.ovf, 0);
    rst_n = 1'b1;

    // PASS mode basics
    passOp(8'd3, 8'd4, 16'd10, 0, 16'd22, 16'd22);
    checkOutput("a_out", bus0.a_out, 3);
    checkOutput("b_out", bus0.b_out, 4);
    checkOutput("a_vld_out", bus0.a_vld_out, 1);
    idle(0);
    checkOutput("a_hold", bus0.a_out, 3);
    checkOutput("a_vld_drop", bus0.a_vld_out, 0);
    checkOutput("c_hold_idle", bus0.c_out, 22);
    passOp(8'hFE, 8'h05, 16'h0003, 1, 16'hFFF9, 16'hFFF9);
    passOp(8'hFE, 8'h05, 16'h0003, 0, 16'h04F9, 16'h04F9);

    // Only A valid: no product, B operand register holds
    expQ0.push_back(16'd5);
    expQ1.push_back(16'd5);
    applyStimulus(8'd9, 1, 8'h77, 0, 16'd5, 1, 0, 0, 0, 0);
    checkOutput("a_load_only", bus0.a_out, 9);
    checkOutput("b_held", bus0.b_out, 8'h05);
    applyStimulus(8'd2, 1, 8'd2, 1, 16'h1234, 0, 0, 0, 0, 0);
    checkOutput("c_discard", bus0.c_out, 5);

    for (int i = 0; i < 8; i++) begin
      ra = DW'($urandom_range(0, 255));
      rb = DW'($urandom_range(0, 255));
      rc = AW'($urandom_range(0, 255));
      if (i[0]) begin
        pv = int'($signed(ra)) * int'($signed(rb)) + int'(rc);
        ex = pv[AW-1:0];
      end else begin
        ex = rc + AW'(ra) * AW'(rb);
      end
      passOp(ra, rb, rc, i[0], ex, ex);
    end
    checkOutput("ovf_clean", bus0.ovf, 0);

    // Overflow handling: dut0 clamps, dut1 wraps, both flag
    passOp(8'h10, 8'h10, 16'hFFF0, 0, 16'hFFFF, 16'h00F0);
    checkOutput("ovf0_set", bus0.ovf, 1);
    checkOutput("ovf1_set", bus1.ovf, 1);
    idle(0);
    checkOutput("ovf_sticky", bus0.ovf, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("ovf0_clear", bus0.ovf, 0);
    checkOutput("ovf1_clear", bus1.ovf, 0);
    passOp(8'h01, 8'h01, 16'h7FFF, 1, 16'h7FFF, 16'h8000);
    passOp(8'hFF, 8'h01, 16'h8000, 1, 16'h8000, 16'h7FFF);
    checkOutput("ovf_signed", bus0.ovf, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    passOp(8'h01, 8'h01, 16'h7FFE, 1, 16'h7FFF, 16'h7FFF);
    checkOutput("ovf_edge_none", bus1.ovf, 0);

    // OS accumulate 6+20+1 and drain
    applyStimulus(8'd2, 1, 8'd3, 1, 0, 0, 1, 0, 0, 0);
    applyStimulus(8'd4, 1, 8'd5, 1, 0, 0, 1, 0, 0, 0);
    applyStimulus(8'd1, 1, 8'd1, 1, 0, 0, 1, 0, 0, 0);
    checkOutput("os_no_vld", bus0.c_vld_out, 0);
    expQ0.push_back(16'd27);
    expQ1.push_back(16'd27);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    checkOutput("drain_vld", bus0.c_vld_out, 1);
    idle(1);
    checkOutput("self_vld0", bus0.c_vld_out, 0);
    checkOutput("self_vld1", bus1.c_vld_out, 0);
    expQ0.push_back(16'd100);
    applyStimulus(8'd3, 1, 8'd3, 1, 16'd100, 1, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 16'hDEAD, 0, 0, 0, 0, 0);
    checkOutput("chain_gap", bus0.c_vld_out, 0);
    expQ0.push_back(16'd200);
    applyStimulus(0, 0, 0, 0, 16'd200, 1, 1, 0, 0, 0);
    idle(1);
    checkOutput("back_in_acc", bus0.c_vld_out, 0);
    expQ0.push_back(16'd9);
    expQ1.push_back(16'd9);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    idle(1);
    expQ0.push_back(16'd55);
    applyStimulus(8'd7, 1, 8'd7, 1, 16'd55, 1, 1, 0, 0, 0);

    // Reset in CHAIN with one word outstanding
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_c_out", bus0.c_out, 0);
    checkOutput("mid_rst_c_vld", bus0.c_vld_out, 0);
    checkOutput("mid_rst_a_out", bus0.a_out, 0);
    checkOutput("mid_rst_c1_out", bus1.c_out, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(8'd5, 1, 8'd6, 1, 0, 0, 1, 0, 0, 0);
    expQ0.push_back(16'd30);
    expQ1.push_back(16'd30);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    idle(1);
    expQ0.push_back(16'd1);
    applyStimulus(0, 0, 0, 0, 16'd1, 1, 1, 0, 0, 0);
    expQ0.push_back(16'd2);
    applyStimulus(0, 0, 0, 0, 16'd2, 1, 1, 0, 0, 0);
    idle(1);
    idle(1);
    checkOutput("end_vld0", bus0.c_vld_out, 0);
    checkOutput("q0_left", expQ0.size(), 0);
    checkOutput("q1_left", expQ1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end
endmodule

// File: doc/pe_mac_cfg.md
Name: pe_mac_cfg

Overview:
- Parametrised successor to the team's fixed 8/16-bit systolic processing element.
- Registers and forwards A (rightward) and B (downward) operands, each with a valid bit.
- Two runtime modes:
  - PASS: partial sum is accumulated from above, as in the existing PE.
  - OS: output-stationary. The result is accumulated locally, then drained down the column through a small FSM.
- Adds signed/unsigned selection, optional saturation and a sticky overflow flag. Instanced as one cell of the parametrised systolic array.

Parameters:
- DATA_WIDTH, 8, operand width of A and B.
- ACC_WIDTH, 16, accumulator and partial-sum width. Must be at least 2*DATA_WIDTH.
- SATURATE, 1, 1 = clamp on overflow, 0 = wrap modulo 2^ACC_WIDTH.
- ROW, 0, row index of this PE in its column, 0 = top. Equals the number of upstream results forwarded during drain.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mode  in  1  0 = PASS, 1 = OS. Sampled only in state ACC.
- signed_en  in  1  1 = operands and accumulator are two's complement.
- clear  in  1  zero the local accumulator and ovf.
- drain  in  1  OS mode: start drain. One-cycle pulse.
- a_in  in  DATA_WIDTH  operand from left.
- a_vld_in  in  1  a_in valid.
- b_in  in  DATA_WIDTH  operand from top.
- b_vld_in  in  1  b_in valid.
- c_in  in  ACC_WIDTH  partial sum / drained result from above.
- c_vld_in  in  1  c_in valid.
- a_out  out  DATA_WIDTH  registered A to the right.
- a_vld_out  out  1  registered a_vld_in.
- b_out  out  DATA_WIDTH  registered B downward.
- b_vld_out  out  1  registered b_vld_in.
- c_out  out  ACC_WIDTH  partial sum / result downward.
- c_vld_out  out  1  c_out valid.
- ovf  out  1  sticky overflow or saturation flag.

Behaviour:
- Reset: all outputs 0, acc = 0, state ACC, drain counter 0. Reset asserted mid-drain aborts the drain immediately.
- Operand pipe, latency 1:
  - a_vld_out <= a_vld_in and b_vld_out <= b_vld_in every cycle.
  - a_out loads a_in only when a_vld_in = 1, otherwise holds. Same rule for b_out.
- fire = a_vld_in & b_vld_in. prod = a_in*b_in as a full 2*DATA_WIDTH product, signed or unsigned per signed_en. When fire = 0, prod = 0.
- Add rule: X + prod is computed in ACC_WIDTH+1 bits. prod is sign- or zero-extended per signed_en.
  - On overflow of ACC_WIDTH, SATURATE=1 clamps to the max/min of the signed or unsigned range. SATURATE=0 wraps.
  - Either case sets ovf. ovf is cleared only by clear or reset.
- PASS mode (mode = 0 in ACC):
  - c_out <= add(c_in, prod) and c_vld_out <= c_vld_in. Latency 1.
  - When c_vld_in = 0, c_out holds and the product is discarded.
  - acc is untouched.
- OS mode FSM, states ACC, SELF, CHAIN:
  - ACC:
    - acc <= add(acc, prod). c_vld_out = 0.
    - On drain: the next cycle presents c_out = add(acc, prod) and c_vld_out = 1. acc <= 0, then go to SELF for that one cycle.
  - SELF:
    - If ROW = 0, go to ACC.
    - Otherwise go to CHAIN with cnt = ROW.
  - CHAIN:
    - Forward c_out <= c_in and c_vld_out <= c_vld_in.
    - Each c_vld_in decrements cnt. When cnt reaches 0, go to ACC.
  - In SELF and CHAIN, fire still accumulates into acc (starting from 0), so the next tile overlaps the drain.
- drain outside ACC, or while mode = 0: ignored.
- clear:
  - acc <= prod (that cycle's product). ovf <= 0.
  - clear together with drain in ACC: the drained value is add(acc, prod), acc <= 0, ovf <= 0.
- mode changes take effect only in ACC. Changes made during SELF or CHAIN are applied after the return to ACC.

Test Plan:
- Reset, then PASS, unsigned, DATA_WIDTH=8, ACC_WIDTH=16: a=3, b=4, c_in=10, all valid -> next cycle c_out=22, c_vld_out=1, a_out=3, b_out=4.
- PASS, signed_en=1: a=0xFE (-2), b=0x05, c_in=0x0003 -> c_out=0xFFF9 (-7). With signed_en=0 -> c_out=0x04F9.
- OS, ROW=2, values: fire (2,3), (4,5), (1,1), then drain -> c_out=27 with c_vld_out=1 for 1 cycle.
- OS drain, continuing: then forward two c_in words 100 and 200 (c_vld_in gaps allowed) -> c_out=100, then 200, then return to ACC with acc=0.
- SATURATE=1, unsigned: c_in=0xFFF0, a=b=0x10 -> c_out=0xFFFF, ovf=1. With SATURATE=0 -> c_out=0x00F0, ovf=1. clear -> ovf=0.
- Reset asserted during CHAIN with cnt=1 -> all outputs 0 and state ACC. A subsequent drain emits only the post-reset acc.
